// File: rtl/lcd_nibble_tx_if.sv
// Byte handshake and 4-bit LCD bus for lcd_nibble_tx.
// LCD_TX_BUSY_POLL_EN adds the bidirectional-bus read-back signals.
interface lcd_nibble_tx_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_byte;
  logic       in_rs;
  logic       in_nibble_only;
  logic [3:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic       busy;
`ifdef LCD_TX_BUSY_POLL_EN
  logic [3:0] lcd_data_in;
  logic       lcd_data_oe;

  modport master (
    output in_valid, in_byte, in_rs, in_nibble_only, lcd_data_in,
    input  in_ready, busy, lcd_data, lcd_rs, lcd_rw, lcd_e, lcd_data_oe
  );
  modport slave (
    input  in_valid, in_byte, in_rs, in_nibble_only, lcd_data_in,
    output in_ready, busy, lcd_data, lcd_rs, lcd_rw, lcd_e, lcd_data_oe
  );
`else
  modport master (
    output in_valid, in_byte, in_rs, in_nibble_only,
    input  in_ready, busy, lcd_data, lcd_rs, lcd_rw, lcd_e
  );
  modport slave (
    input  in_valid, in_byte, in_rs, in_nibble_only,
    output in_ready, busy, lcd_data, lcd_rs, lcd_rw, lcd_e
  );
`endif
endinterface

// File: rtl/lcd_nibble_tx.sv
// HD44780 4-bit bus transmitter: byte -> two E-strobed nibbles + execution delay.
// Optional LCD_TX_BUSY_POLL_EN replaces the fixed delay with busy-flag polling.
module lcd_nibble_tx #(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned HOLD_CYC       = 1,
  parameter int unsigned NIBBLE_GAP_CYC = 50,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned LONG_WAIT_CYC  = 82000
) (
  input logic            clk,
  input logic            reset,
  lcd_nibble_tx_if.slave bus
);
  localparam int unsigned CW = $clog2(LONG_WAIT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, SETUP_HI, EHI_HI, HOLD_HI, GAP, SETUP_LO, EHI_LO, HOLD_LO, WAIT
`ifdef LCD_TX_BUSY_POLL_EN
    , P_SETUP1, P_EHI1, P_HOLD1, P_SETUP2, P_EHI2, P_HOLD2, P_GAP
`endif
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    byte_q;
  logic          rs_q;
  logic          nib_q;
  logic [3:0]    data_q;
  logic          lrs_q;
  logic          rw_q;
  logic          e_q;
  logic          ready_q;
  logic          long_wait;

  function automatic logic [CW-1:0] reload(input int unsigned n);
    return CW'(n - 1);
  endfunction

  // Clear (0x01) and Home (0x02/0x03) need the long execution time.
  assign long_wait = !rs_q && !nib_q && (byte_q[7:2] == 6'd0);

`ifdef LCD_TX_BUSY_POLL_EN
  logic          oe_q;
  logic          bf_q;
  logic [CW-1:0] tmo;
  logic          is_poll;

  always_comb begin
    is_poll = 1'b0;
    case (state)
      P_SETUP1, P_EHI1, P_HOLD1, P_SETUP2, P_EHI2, P_HOLD2, P_GAP: is_poll = 1'b1;
      default: is_poll = 1'b0;
    endcase
  end

  assign bus.lcd_data_oe = oe_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      nib_q   <= 1'b0;
      data_q  <= '0;
      lrs_q   <= 1'b0;
      rw_q    <= 1'b0;
      e_q     <= 1'b0;
      ready_q <= 1'b0;
`ifdef LCD_TX_BUSY_POLL_EN
      oe_q    <= 1'b0;
      bf_q    <= 1'b0;
      tmo     <= '0;
`endif
    end else begin
      if (state == IDLE) begin
        if (ready_q && bus.in_valid) begin
          byte_q  <= bus.in_byte;
          rs_q    <= bus.in_rs;
          nib_q   <= bus.in_nibble_only;
          data_q  <= bus.in_byte[7:4];
          lrs_q   <= bus.in_rs;
          rw_q    <= 1'b0;
          ready_q <= 1'b0;
          state   <= SETUP_HI;
          cnt     <= reload(SETUP_CYC);
`ifdef LCD_TX_BUSY_POLL_EN
          oe_q    <= 1'b1;
`endif
        end else begin
          ready_q <= 1'b1;
        end
      end else if (cnt != '0) begin
        cnt <= cnt - CW'(1);
      end else begin
        case (state)
          SETUP_HI: begin state <= EHI_HI;  cnt <= reload(E_HIGH_CYC); e_q <= 1'b1; end
          EHI_HI:   begin state <= HOLD_HI; cnt <= reload(HOLD_CYC);   e_q <= 1'b0; end
          HOLD_HI: begin
            if (nib_q) begin
              state <= WAIT;
              cnt   <= reload(CMD_WAIT_CYC);
            end else begin
              state <= GAP;
              cnt   <= reload(NIBBLE_GAP_CYC);
            end
          end
          GAP: begin
            state  <= SETUP_LO;
            cnt    <= reload(SETUP_CYC);
            data_q <= byte_q[3:0];
          end
          SETUP_LO: begin state <= EHI_LO;  cnt <= reload(E_HIGH_CYC); e_q <= 1'b1; end
          EHI_LO:   begin state <= HOLD_LO; cnt <= reload(HOLD_CYC);   e_q <= 1'b0; end
          HOLD_LO: begin
`ifdef LCD_TX_BUSY_POLL_EN
            state <= P_SETUP1;
            cnt   <= reload(SETUP_CYC);
            tmo   <= reload(LONG_WAIT_CYC);
            lrs_q <= 1'b0;
            rw_q  <= 1'b1;
            oe_q  <= 1'b0;
`else
            state <= WAIT;
            cnt   <= long_wait ? reload(LONG_WAIT_CYC) : reload(CMD_WAIT_CYC);
`endif
          end
          WAIT: begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
`ifdef LCD_TX_BUSY_POLL_EN
          P_SETUP1: begin state <= P_EHI1;  cnt <= reload(E_HIGH_CYC); e_q <= 1'b1; end
          P_EHI1: begin
            state <= P_HOLD1;
            cnt   <= reload(HOLD_CYC);
            e_q   <= 1'b0;
            bf_q  <= bus.lcd_data_in[3];
          end
          P_HOLD1:  begin state <= P_SETUP2; cnt <= reload(SETUP_CYC);  end
          P_SETUP2: begin state <= P_EHI2;   cnt <= reload(E_HIGH_CYC); e_q <= 1'b1; end
          P_EHI2:   begin state <= P_HOLD2;  cnt <= reload(HOLD_CYC);   e_q <= 1'b0; end
          P_HOLD2: begin
            if (bf_q) begin
              state <= P_GAP;
              cnt   <= reload(NIBBLE_GAP_CYC);
            end else begin
              state   <= IDLE;
              rw_q    <= 1'b0;
              ready_q <= 1'b1;
            end
          end
          P_GAP: begin state <= P_SETUP1; cnt <= reload(SETUP_CYC); end
`endif
          default: state <= IDLE;
        endcase
      end
`ifdef LCD_TX_BUSY_POLL_EN
      // Placed last so the timeout overrides whatever the poll sequence scheduled.
      if (is_poll) begin
        if (tmo == '0) begin
          state   <= IDLE;
          e_q     <= 1'b0;
          rw_q    <= 1'b0;
          ready_q <= 1'b1;
        end else begin
          tmo <= tmo - CW'(1);
        end
      end
`endif
    end
  end

  assign bus.in_ready = ready_q;
  assign bus.busy     = ~ready_q;
  assign bus.lcd_data = data_q;
  assign bus.lcd_rs   = lrs_q;
  assign bus.lcd_rw   = rw_q;
  assign bus.lcd_e    = e_q;
endmodule
